// File: rtl/hazard_pkg.sv
// Shared constants for the multi-cycle hazard controller: forward-select
// codes and the data-memory wait FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/md_scoreboard.sv
// Mul/div scoreboard: latency down-counter, completion pulse, destination
// tracking and the ID-stage hazards it raises.
module md_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              freeze,
  input  logic [REG_AW-1:0] dest,
  input  logic              id_md_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_wr_addr,
  output logic              sb_stall,
  output logic              md_struct
);

  localparam int unsigned CW = 4;

  logic [CW-1:0] cnt;
  logic          accept;

  // A start is only taken while idle, which includes the md_done cycle.
  assign accept  = start && !freeze && (cnt == '0);
  assign md_busy = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      md_done    <= 1'b0;
      md_wr_addr <= '0;
    end else begin
      md_done <= (cnt == CW'(1));
      if (accept) begin
        cnt        <= CW'(MD_LAT);
        md_wr_addr <= dest;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    sb_stall  = 1'b0;
    md_struct = 1'b0;
    if ((md_busy || md_done) && (md_wr_addr != '0) &&
        ((md_wr_addr == id_rs) || (md_wr_addr == id_rt)))
      sb_stall = 1'b1;
    if (id_md_op && md_busy)
      md_struct = 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with mul/div
// scoreboarding, data-memory wait handling and a stall-cycle counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MD_LAT      = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_branch,
  input  logic              id_md_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_reg_wr_en,
  input  logic              ex_mem_to_reg,
  input  logic [REG_AW-1:0] ex_reg_wr_addr,
  input  logic              ex_md_start,
  input  logic [REG_AW-1:0] ex_md_dest,
  input  logic              mem_reg_wr_en,
  input  logic              mem_mem_to_reg,
  input  logic [REG_AW-1:0] mem_reg_wr_addr,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              wb_reg_wr_en,
  input  logic [REG_AW-1:0] wb_reg_wr_addr,
  input  logic              stat_clr,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_ex,
  output logic              freeze,
  output logic [1:0]        forwardA_ex,
  output logic [1:0]        forwardB_ex,
  output logic              forwardA_id,
  output logic              forwardB_id,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_wr_addr,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

  mem_state_t    state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          timeout;
  logic          lw_stall, br_stall, sb_stall, md_struct, hz;
  logic          mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b;

  md_scoreboard #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT)
  ) u_md (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (ex_md_start),
    .freeze     (freeze),
    .dest       (ex_md_dest),
    .id_md_op   (id_md_op),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_wr_addr (md_wr_addr),
    .sb_stall   (sb_stall),
    .md_struct  (md_struct)
  );

  always_comb begin
    mem_fwd_a   = mem_reg_wr_en && (mem_reg_wr_addr != '0) && (mem_reg_wr_addr == ex_rs);
    mem_fwd_b   = mem_reg_wr_en && (mem_reg_wr_addr != '0) && (mem_reg_wr_addr == ex_rt);
    wb_fwd_a    = wb_reg_wr_en && (wb_reg_wr_addr != '0) && (wb_reg_wr_addr == ex_rs);
    wb_fwd_b    = wb_reg_wr_en && (wb_reg_wr_addr != '0) && (wb_reg_wr_addr == ex_rt);
    forwardA_ex = mem_fwd_a ? FWD_MEM : (wb_fwd_a ? FWD_WB : FWD_RF);
    forwardB_ex = mem_fwd_b ? FWD_MEM : (wb_fwd_b ? FWD_WB : FWD_RF);
    forwardA_id = mem_reg_wr_en && (mem_reg_wr_addr != '0) && (mem_reg_wr_addr == id_rs);
    forwardB_id = mem_reg_wr_en && (mem_reg_wr_addr != '0) && (mem_reg_wr_addr == id_rt);
  end

  always_comb begin
    lw_stall = ex_mem_to_reg && ((ex_reg_wr_addr == id_rs) || (ex_reg_wr_addr == id_rt));
    br_stall = id_branch &&
               ((ex_reg_wr_en && ((ex_reg_wr_addr == id_rs) || (ex_reg_wr_addr == id_rt))) ||
                (mem_mem_to_reg && ((mem_reg_wr_addr == id_rs) || (mem_reg_wr_addr == id_rt))));
    hz       = lw_stall || br_stall || sb_stall || md_struct;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= M_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= timeout;
    end
  end

  // Freeze is derived from the request itself so zero-wait accesses never
  // freeze; the FSM only tracks how long a stalled access has been waiting.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout      = 1'b0;
    case (state)
      M_IDLE: begin
        wait_cnt_nxt = '0;
        if (mem_req && !mem_ready) begin
          state_nxt    = M_WAIT;
          wait_cnt_nxt = WW'(1);
        end
      end
      M_WAIT: begin
        if (!mem_req || mem_ready) begin
          state_nxt    = M_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
          timeout      = 1'b1;
          state_nxt    = M_IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WW'(1);
        end
      end
      default: begin
        state_nxt    = M_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
    freeze   = mem_req && !mem_ready && !timeout;
    stall_if = hz || freeze;
    stall_id = hz || freeze;
    flush_ex = hz && !freeze;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stat_clr)
      stall_cycles <= '0;
    else if (stall_if && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a cycle-level integer model of the controller rules.
module tb_hazard_ctrl_mc;

  localparam int MD_LAT      = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 6;
  localparam int SMAX        = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_branch, id_md_op;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
  logic       ex_reg_wr_en, ex_mem_to_reg;
  logic [4:0] ex_reg_wr_addr;
  logic       ex_md_start;
  logic [4:0] ex_md_dest;
  logic       mem_reg_wr_en, mem_mem_to_reg;
  logic [4:0] mem_reg_wr_addr;
  logic       mem_req, mem_ready;
  logic       wb_reg_wr_en;
  logic [4:0] wb_reg_wr_addr;
  logic       stat_clr;
  logic       stall_if, stall_id, flush_ex, freeze;
  logic [1:0] forwardA_ex, forwardB_ex;
  logic       forwardA_id, forwardB_id;
  logic       md_busy, md_done;
  logic [4:0] md_wr_addr;
  logic       mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int         md_rem;
  bit         md_dn;
  logic [4:0] md_dst;
  int         wait_n;
  bit         err_m;
  int         scnt;
  // model combinational results for the current inputs
  bit         e_hz, e_frz, e_tmo;

  hazard_ctrl_mc #(
    .REG_AW      (5),
    .MD_LAT      (MD_LAT),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .id_branch (id_branch), .id_md_op (id_md_op),
    .id_rs (id_rs), .id_rt (id_rt), .ex_rs (ex_rs), .ex_rt (ex_rt),
    .ex_reg_wr_en (ex_reg_wr_en), .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_wr_addr (ex_reg_wr_addr),
    .ex_md_start (ex_md_start), .ex_md_dest (ex_md_dest),
    .mem_reg_wr_en (mem_reg_wr_en), .mem_mem_to_reg (mem_mem_to_reg),
    .mem_reg_wr_addr (mem_reg_wr_addr),
    .mem_req (mem_req), .mem_ready (mem_ready),
    .wb_reg_wr_en (wb_reg_wr_en), .wb_reg_wr_addr (wb_reg_wr_addr),
    .stat_clr (stat_clr),
    .stall_if (stall_if), .stall_id (stall_id), .flush_ex (flush_ex),
    .freeze (freeze),
    .forwardA_ex (forwardA_ex), .forwardB_ex (forwardB_ex),
    .forwardA_id (forwardA_id), .forwardB_id (forwardB_id),
    .md_busy (md_busy), .md_done (md_done), .md_wr_addr (md_wr_addr),
    .mem_err (mem_err), .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit uses(input logic [4:0] r);
    return (r == id_rs) || (r == id_rt);
  endfunction

  function automatic logic [1:0] exp_fwd_ex(input logic [4:0] src);
    if (mem_reg_wr_en && mem_reg_wr_addr != 0 && mem_reg_wr_addr == src) return 2'b10;
    if (wb_reg_wr_en && wb_reg_wr_addr != 0 && wb_reg_wr_addr == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_fwd_id(input logic [4:0] src);
    return mem_reg_wr_en && mem_reg_wr_addr != 0 && mem_reg_wr_addr == src;
  endfunction

  task automatic model_comb();
    bit lw, br, sb, st;
    lw    = ex_mem_to_reg && uses(ex_reg_wr_addr);
    br    = id_branch && ((ex_reg_wr_en && uses(ex_reg_wr_addr)) ||
                          (mem_mem_to_reg && uses(mem_reg_wr_addr)));
    sb    = (md_rem > 0 || md_dn) && md_dst != 0 && uses(md_dst);
    st    = id_md_op && md_rem > 0;
    e_hz  = lw || br || sb || st;
    e_tmo = (wait_n == MEM_TIMEOUT) && mem_req && !mem_ready;
    e_frz = mem_req && !mem_ready && !e_tmo;
  endtask

  task automatic model_reset();
    md_rem = 0; md_dn = 0; md_dst = 0; wait_n = 0; err_m = 0; scnt = 0;
  endtask

  task automatic model_update();
    bit start;
    start  = ex_md_start && !e_frz && md_rem == 0;
    md_dn  = (md_rem == 1);
    if (start) begin
      md_rem = MD_LAT;
      md_dst = ex_md_dest;
    end else if (md_rem > 0) begin
      md_rem = md_rem - 1;
    end
    err_m  = e_tmo;
    if (e_tmo) wait_n = 0;
    else if (mem_req && !mem_ready) wait_n = wait_n + 1;
    else wait_n = 0;
    if (stat_clr) scnt = 0;
    else if ((e_hz || e_frz) && scnt < SMAX) scnt = scnt + 1;
  endtask

  task automatic compare_all();
    model_comb();
    chk("stall_if", stall_if, e_hz || e_frz);
    chk("stall_id", stall_id, e_hz || e_frz);
    chk("flush_ex", flush_ex, e_hz && !e_frz);
    chk("freeze", freeze, e_frz);
    chk("forwardA_ex", forwardA_ex, exp_fwd_ex(ex_rs));
    chk("forwardB_ex", forwardB_ex, exp_fwd_ex(ex_rt));
    chk("forwardA_id", forwardA_id, exp_fwd_id(id_rs));
    chk("forwardB_id", forwardB_id, exp_fwd_id(id_rt));
    chk("md_busy", md_busy, md_rem > 0);
    chk("md_done", md_done, md_dn);
    chk("md_wr_addr", md_wr_addr, md_dst);
    chk("mem_err", mem_err, err_m);
    chk("stall_cycles", stall_cycles, scnt);
  endtask

  // Called at a negedge after inputs are driven: check, clock, advance model.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_branch = 0; id_md_op = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_reg_wr_en = 0; ex_mem_to_reg = 0; ex_reg_wr_addr = 0;
    ex_md_start = 0; ex_md_dest = 0;
    mem_reg_wr_en = 0; mem_mem_to_reg = 0; mem_reg_wr_addr = 0;
    mem_req = 0; mem_ready = 0; wb_reg_wr_en = 0; wb_reg_wr_addr = 0;
    stat_clr = 0;
  endtask

  initial begin
    int n, didx;
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_md_done", md_done, 0);
    chk("rst_md_wr_addr", md_wr_addr, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    @(negedge clk);
    rst_n = 1;

    // load-use: one cycle of stall+flush, gone once the load moves on
    ex_mem_to_reg = 1; ex_reg_wr_addr = 8; id_rs = 8;
    #1;
    chk("lw_stall_if", stall_if, 1);
    chk("lw_stall_id", stall_id, 1);
    chk("lw_flush", flush_ex, 1);
    tick();
    clear_inputs();
    #1;
    chk("lw_after", stall_if, 0);
    tick();

    // forwarding priority and register 0
    ex_rs = 3; mem_reg_wr_en = 1; mem_reg_wr_addr = 3; wb_reg_wr_en = 1; wb_reg_wr_addr = 3;
    #1;
    chk("fwd_mem_prio", forwardA_ex, 2'b10);
    tick();
    mem_reg_wr_en = 0;
    #1;
    chk("fwd_wb", forwardA_ex, 2'b01);
    tick();
    ex_rs = 0; mem_reg_wr_en = 1; mem_reg_wr_addr = 0; wb_reg_wr_addr = 0;
    #1;
    chk("fwd_r0", forwardA_ex, 2'b00);
    tick();
    clear_inputs();

    // mul/div scoreboard stall: 4 busy cycles + done cycle
    ex_md_start = 1; ex_md_dest = 9;
    tick();
    clear_inputs();
    id_rs = 9;
    n = 0; didx = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (stall_if) n++;
      if (md_done) didx = i;
      if (i == 0) chk("md_addr_9", md_wr_addr, 9);
      tick();
    end
    chk("md_stall_cycles", n, 5);
    chk("md_done_index", didx, 4);
    clear_inputs();

    // structural stall; start while busy is ignored
    ex_md_start = 1; ex_md_dest = 0;
    tick();
    clear_inputs();
    id_md_op = 1; ex_md_start = 1; ex_md_dest = 5;
    #1;
    chk("md_struct_stall", stall_if, 1);
    tick();
    clear_inputs();
    #1;
    chk("md_ignored_start", md_wr_addr, 0);
    for (int i = 0; i < 5; i++) tick();

    // memory wait: 3 frozen cycles, concurrent load-use does not flush
    for (int i = 0; i < 3; i++) begin
      mem_req = 1; mem_ready = 0;
      if (i == 1) begin ex_mem_to_reg = 1; ex_reg_wr_addr = 4; id_rt = 4; end
      else begin ex_mem_to_reg = 0; ex_reg_wr_addr = 0; id_rt = 0; end
      #1;
      chk("mem_freeze", freeze, 1);
      chk("mem_no_flush", flush_ex, 0);
      tick();
    end
    clear_inputs();
    mem_req = 1; mem_ready = 1;
    #1;
    chk("mem_ready_nofreeze", freeze, 0);
    tick();
    clear_inputs();
    #1;
    chk("mem_no_err", mem_err, 0);
    tick();

    // timeout: 16 frozen cycles, then timeout cycle, then a single mem_err
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      chk("tmo_freeze", freeze, 1);
      tick();
    end
    #1;
    chk("tmo_unfreeze", freeze, 0);
    chk("tmo_err_pre", mem_err, 0);
    tick();
    mem_req = 0;
    #1;
    chk("tmo_err_pulse", mem_err, 1);
    tick();
    #1;
    chk("tmo_err_once", mem_err, 0);
    tick();

    // async reset mid mul/div and mid wait
    ex_md_start = 1; ex_md_dest = 7; mem_req = 1; mem_ready = 0;
    tick();
    ex_md_start = 0;
    tick();
    #1;
    rst_n = 0;
    #1;
    chk("arst_md_busy", md_busy, 0);
    chk("arst_md_wr_addr", md_wr_addr, 0);
    chk("arst_stall_cycles", stall_cycles, 0);
    chk("arst_mem_err", mem_err, 0);
    model_reset();
    rst_n = 1;
    mem_req = 0;
    tick();

    // saturation and clear priority
    ex_mem_to_reg = 1; ex_reg_wr_addr = 2; id_rs = 2;
    for (int i = 0; i < SMAX + 6; i++) tick();
    #1;
    chk("sat_hold", stall_cycles, SMAX);
    stat_clr = 1;
    tick();
    stat_clr = 0;
    #1;
    chk("sat_clr", stall_cycles, 0);
    tick();
    clear_inputs();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id_branch       = ($urandom_range(0, 3) == 0);
      id_md_op        = ($urandom_range(0, 3) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rs           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_reg_wr_en    = 1'($urandom_range(0, 1));
      ex_mem_to_reg   = ($urandom_range(0, 3) == 0);
      ex_reg_wr_addr  = 5'($urandom_range(0, 3));
      ex_md_start     = ($urandom_range(0, 3) == 0);
      ex_md_dest      = 5'($urandom_range(0, 3));
      mem_reg_wr_en   = 1'($urandom_range(0, 1));
      mem_mem_to_reg  = ($urandom_range(0, 3) == 0);
      mem_reg_wr_addr = 5'($urandom_range(0, 3));
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = 1'($urandom_range(0, 1));
      wb_reg_wr_en    = 1'($urandom_range(0, 1));
      wb_reg_wr_addr  = 5'($urandom_range(0, 3));
      stat_clr        = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
